// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the RISC-V Lite pipeline: sized loads/stores over a req/ack bus, branch redirect, stall.
// Optional request abort after TIMEOUT cycles when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_eq0,
  input  logic              in_reg_write,
  input  logic              in_branch,
  input  logic              in_bit_branch,
  input  logic              in_jump,
  input  logic [DATA_W-1:0] in_pc_jump,
  output logic              stall_o,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  mem_access_stage_if.master dmem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_wb_en,
  output logic              misalign_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state_reg, state_next;

  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [3:0]        be_reg, be_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_result_reg, out_result_next;
  logic [4:0]        out_rd_reg, out_rd_next;
  logic              out_wb_en_reg, out_wb_en_next;
  logic              err_reg, err_next;
  logic [4:0]        rd_lat_reg, rd_lat_next;
  logic [2:0]        f3_lat_reg, f3_lat_next;
  logic [1:0]        off_lat_reg, off_lat_next;
  logic              wb_lat_reg, wb_lat_next;
  logic              load_lat_reg, load_lat_next;

  logic is_load, is_store, is_mem, f3_ok, misalign, legal_mem, wb_req;
  logic timeout_hit;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] lane_shift;
  logic [DATA_W-1:0] load_data;

  // A load wins when both read and write are flagged.
  assign is_load  = in_mem_read;
  assign is_store = in_mem_write & ~in_mem_read;
  assign is_mem   = is_load | is_store;
  assign wb_req   = in_reg_write & ~in_rd_eq0;

  always_comb begin
    f3_ok = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misalign  = is_mem & (~f3_ok
                   | ((in_funct3[1:0] == 2'b01) & in_alu_res[0])
                   | ((in_funct3[1:0] == 2'b10) & (in_alu_res[1:0] != 2'b00)));
  assign legal_mem = is_mem & ~misalign;

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   be_calc = 4'b0001 << in_alu_res[1:0];
      2'b01:   be_calc = 4'b0011 << {in_alu_res[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_rep[8*gi +: 8] = (in_funct3[1:0] == 2'b00) ? in_wdata[7:0] :
                                  (in_funct3[1:0] == 2'b01) ? in_wdata[8*(gi%2) +: 8] :
                                                              in_wdata[8*gi +: 8];
  end

  assign lane_shift = dmem.rdata >> {off_lat_reg, 3'b000};

  always_comb begin
    case (f3_lat_reg)
      3'b000:  load_data = {{(DATA_W-8){lane_shift[7]}}, lane_shift[7:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, lane_shift[7:0]};
      3'b001:  load_data = {{(DATA_W-16){lane_shift[15]}}, lane_shift[15:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, lane_shift[15:0]};
      default: load_data = dmem.rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  // Abort on the cycle whose increment would bring the count to TIMEOUT.
  assign timeout_hit = (state_reg == REQ) & ~dmem.ack & (to_cnt_reg == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (state_reg == IDLE && in_valid)
      to_cnt_next = '0;
    else if (state_reg == REQ && !dmem.ack)
      to_cnt_next = to_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) to_cnt_reg <= '0;
    else       to_cnt_reg <= to_cnt_next;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Stall drops in the ack/abort cycle so upstream advances on the completing edge.
  assign stall_o   = ((state_reg == IDLE) & in_valid & legal_mem)
                   | ((state_reg == REQ) & ~dmem.ack & ~timeout_hit);
  assign pc_src    = in_valid & ((in_branch & in_bit_branch) | in_jump) & ~stall_o;
  assign pc_target = in_pc_jump;

  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    be_next         = be_reg;
    wdata_next      = wdata_reg;
    out_valid_next  = 1'b0;
    out_result_next = out_result_reg;
    out_rd_next     = out_rd_reg;
    out_wb_en_next  = out_wb_en_reg;
    err_next        = 1'b0;
    rd_lat_next     = rd_lat_reg;
    f3_lat_next     = f3_lat_reg;
    off_lat_next    = off_lat_reg;
    wb_lat_next     = wb_lat_reg;
    load_lat_next   = load_lat_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (legal_mem) begin
            state_next    = REQ;
            req_next      = 1'b1;
            we_next       = is_store;
            addr_next     = {in_alu_res[DATA_W-1:2], 2'b00};
            be_next       = be_calc;
            wdata_next    = wdata_rep;
            rd_lat_next   = in_rd;
            f3_lat_next   = in_funct3;
            off_lat_next  = in_alu_res[1:0];
            wb_lat_next   = is_load & wb_req;
            load_lat_next = is_load;
          end else begin
            out_valid_next  = 1'b1;
            out_result_next = in_alu_res;
            out_rd_next     = in_rd;
            out_wb_en_next  = wb_req & ~misalign;
            err_next        = misalign;
          end
        end
      end
      REQ: begin
        if (dmem.ack) begin
          state_next      = IDLE;
          req_next        = 1'b0;
          we_next         = 1'b0;
          out_valid_next  = 1'b1;
          out_rd_next     = rd_lat_reg;
          out_wb_en_next  = wb_lat_reg;
          out_result_next = load_lat_reg ? load_data : {addr_reg[DATA_W-1:2], off_lat_reg};
        end else if (timeout_hit) begin
          state_next     = IDLE;
          req_next       = 1'b0;
          we_next        = 1'b0;
          out_valid_next = 1'b1;
          out_rd_next    = rd_lat_reg;
          out_wb_en_next = 1'b0;
          err_next       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_rd_reg     <= '0;
      out_wb_en_reg  <= 1'b0;
      err_reg        <= 1'b0;
      rd_lat_reg     <= '0;
      f3_lat_reg     <= '0;
      off_lat_reg    <= '0;
      wb_lat_reg     <= 1'b0;
      load_lat_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
      out_valid_reg  <= out_valid_next;
      out_result_reg <= out_result_next;
      out_rd_reg     <= out_rd_next;
      out_wb_en_reg  <= out_wb_en_next;
      err_reg        <= err_next;
      rd_lat_reg     <= rd_lat_next;
      f3_lat_reg     <= f3_lat_next;
      off_lat_reg    <= off_lat_next;
      wb_lat_reg     <= wb_lat_next;
      load_lat_reg   <= load_lat_next;
    end
  end

  assign dmem.req     = req_reg;
  assign dmem.we      = we_reg;
  assign dmem.addr    = addr_reg;
  assign dmem.be      = be_reg;
  assign dmem.wdata   = wdata_reg;
  assign out_valid    = out_valid_reg;
  assign out_result   = out_result_reg;
  assign out_rd       = out_rd_reg;
  assign out_wb_en    = out_wb_en_reg;
  assign misalign_err = err_reg;

endmodule
